// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline stage with 2-entry skid, flush and field override.
// Optional PIPE_STAGE_STATS_EN adds saturating stall_cnt/full_cnt outputs.
module pipe_stage_elastic #(
  parameter int DATA_W  = 192,
  parameter int FWD_LSB = 64,
  parameter int FWD_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              fwd_en,
  input  logic [FWD_W-1:0]  fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       full_cnt
`endif
);
  if (FWD_W < 1 || FWD_LSB + FWD_W > DATA_W) begin : g_bad_params
    $error("pipe_stage_elastic: override field out of range");
  end
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d, word;
  logic accept, pop;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign occupancy = state_q;
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_comb begin
    word = in_data;
    if (fwd_en) word[FWD_LSB +: FWD_W] = fwd_data;
  end
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        main_d  = word;
      end
      ONE: if (accept && pop) main_d = word;
      else if (accept) begin
        state_d = FULL;
        skid_d  = word;
      end
      else if (pop) state_d = EMPTY;
      FULL: if (pop) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // flush drops the state only; data registers keep stale words
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, full_cnt_q, full_cnt_d;
  assign stall_cnt = stall_cnt_q;
  assign full_cnt  = full_cnt_q;
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'b0, out_valid & ~out_ready & ~&stall_cnt_q};
    full_cnt_d  = full_cnt_q + {31'b0, (state_q == FULL) & ~&full_cnt_q};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      full_cnt_q  <= full_cnt_d;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench; the reference is a bounded FIFO of captured words.
module tb_pipe_stage_elastic;
  localparam int DW = 192, FL = 64, FW = 32;
  logic clk = 0, rst, flush, in_valid, in_ready, fwd_en, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [FW-1:0] fwd_data;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt, full_cnt;
  longint stall_m = 0, full_m = 0;
`endif
  int checks = 0, errors = 0;
  bit mon_en = 0;
  logic [DW-1:0] exp_q[$];

  pipe_stage_elastic #(.DATA_W(DW), .FWD_LSB(FL), .FWD_W(FW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fwd_en(fwd_en), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .full_cnt(full_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] cap(input logic [DW-1:0] d, input logic fe, input logic [FW-1:0] fd);
    logic [DW-1:0] m;
    m = DW'({FW{1'b1}}) << FL;
    return fe ? (d & ~m) | (DW'(fd) << FL) : d;
  endfunction

  // monitor: status against queue depth, head word against out_data, pop on transfer
  always @(negedge clk) if (mon_en && !rst) begin
    chk("occupancy", DW'(occupancy), DW'(exp_q.size()));
    chk("in_ready", DW'(in_ready), DW'(exp_q.size() < 2));
    chk("out_valid", DW'(out_valid), DW'(exp_q.size() != 0));
    if (exp_q.size() != 0 && out_valid) begin
      chk("out_data", out_data, exp_q[0]);
      if (out_ready) void'(exp_q.pop_front());
    end
`ifdef PIPE_STAGE_STATS_EN
    if (exp_q.size() != 0 && !out_ready && stall_m < 64'hFFFF_FFFF) stall_m++;
    if (exp_q.size() == 2 && full_m < 64'hFFFF_FFFF) full_m++;
`endif
  end

  // drive one cycle; the expected word is queued once the capturing edge has passed
  task automatic step(input logic v, input logic [DW-1:0] d, input logic fe,
                      input logic [FW-1:0] fd, input logic ordy, input logic fl);
    bit acc;
    in_valid = v; in_data = d; fwd_en = fe; fwd_data = fd; out_ready = ordy; flush = fl;
    acc = v && exp_q.size() < 2;
    @(posedge clk); #1;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(cap(d, fe, fd));
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(0, '0, 0, '0, 1, 0);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_data = '0; fwd_en = 0; fwd_data = '0; out_ready = 0;
    @(posedge clk); #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_occupancy", DW'(occupancy), '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    rst = 0; mon_en = 1;
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, '0, 1, 0);
    drain();
    step(1, DW'('hA), 0, '0, 0, 0);
    step(1, DW'('hB), 0, '0, 0, 0);
    step(1, DW'('hC), 0, '0, 0, 0);
    chk("bp_in_ready", DW'(in_ready), '0);
    step(1, DW'('hC), 0, '0, 1, 0);
    step(1, DW'('hC), 0, '0, 1, 0);
    drain();
    step(1, '1, 1, 32'hDEADBEEF, 1, 0);
    chk("fwd_on", out_data, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF, 64'hFFFF_FFFF_FFFF_FFFF});
    step(1, '1, 0, 32'hDEADBEEF, 1, 0);
    chk("fwd_off", out_data, '1);
    drain();
    step(1, DW'('h11), 0, '0, 0, 0);
    step(1, DW'('h22), 0, '0, 0, 0);
    step(1, DW'('h33), 0, '0, 0, 1);
    chk("flush_occ", DW'(occupancy), '0);
    drain();
    step(1, DW'('h44), 0, '0, 0, 0);
    step(1, DW'('h55), 0, '0, 0, 0);
    #1 rst = 1;
    #1;
    chk("arst_out_valid", DW'(out_valid), '0);
    chk("arst_out_data", out_data, '0);
    chk("arst_occupancy", DW'(occupancy), '0);
    chk("arst_in_ready", DW'(in_ready), DW'(1));
    exp_q.delete();
`ifdef PIPE_STAGE_STATS_EN
    stall_m = 0; full_m = 0;
`endif
    #1 rst = 0;
    step(1, DW'('h5), 0, '0, 0, 0);
    chk("post_rst_word", out_data, DW'('h5));
    drain();
    for (int i = 0; i < 600; i++)
      step(1'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           1'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 15) == 0);
    drain();
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", DW'(stall_cnt), DW'(stall_m));
    chk("full_cnt", DW'(full_cnt), DW'(full_m));
`endif
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
